// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: multi-channel serial ADC sequencer.
// Settles the analog mux, clocks a 16-bit ADC frame and strobes 12-bit results.
module adc_seq_ctrl #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        enable,
    input  logic        single_shot,
    input  logic [3:0]  ch_mask,
    input  logic [15:0] period,
    input  logic        clr_ovr,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    input  logic        adc_sdata,
    output logic [1:0]  ch_sel,
    output logic        sample_valid,
    output logic [1:0]  sample_ch,
    output logic [11:0] sample_data,
    output logic        busy,
    output logic        overrun
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] FRAME  = 2'd2;
    localparam logic [1:0] STORE  = 2'd3;

    localparam logic [7:0] DIV_LAST    = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [3:0]  mask_q, mask_d;
    logic [1:0]  ch_q, ch_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  phase_q, phase_d;
    logic [11:0] shift_q, shift_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        busy_q, busy_d;
    logic        ovr_q, ovr_d;
    logic        valid_q, valid_d;
    logic [1:0]  sch_q, sch_d;
    logic [11:0] sdata_q, sdata_d;

    logic        tmr_fire;
    logic        trig;
    logic [3:0]  rem_mask;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Trigger generation, sequencing FSM and next-state of every output register
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        mask_d   = mask_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        phase_d  = phase_q;
        shift_d  = shift_q;
        sclk_d   = sclk_q;
        ovr_d    = ovr_q;
        valid_d  = 1'b0;
        sch_d    = sch_q;
        sdata_d  = sdata_q;
        rem_mask = mask_q & ~(4'b0001 << ch_q);

        // >= also catches a period lowered below the running count
        tmr_fire = enable && (period != 16'd0) && (tmr_q >= period - 16'd1);
        trig     = single_shot || tmr_fire;

        if (!enable || period == 16'd0 || tmr_fire) tmr_d = 16'd0;
        else                                         tmr_d = tmr_q + 16'd1;

        // A dropped trigger wins over a simultaneous clear
        if (trig && state_q != IDLE) ovr_d = 1'b1;
        else if (clr_ovr)            ovr_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig && ch_mask != 4'd0) begin
                    mask_d  = ch_mask;
                    ch_d    = lowest(ch_mask);
                    cnt_d   = 8'd0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = FRAME;
                    div_d   = 8'd0;
                    phase_d = 5'd0;
                    sclk_d  = 1'b0;
                    shift_d = 12'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FRAME: begin
                if (div_q == DIV_LAST) begin
                    div_d  = 8'd0;
                    sclk_d = ~sclk_q;
                    // sclk is about to rise: capture the bit held while it was low
                    if (!sclk_q) shift_d = {shift_q[10:0], adc_sdata};
                    if (phase_q == 5'd31) begin
                        state_d = STORE;
                        sclk_d  = 1'b1;
                        valid_d = 1'b1;
                        sch_d   = ch_q;
                        sdata_d = shift_q;
                    end else begin
                        phase_d = phase_q + 5'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                mask_d = rem_mask;
                if (rem_mask != 4'd0) begin
                    ch_d    = lowest(rem_mask);
                    cnt_d   = 8'd0;
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        cs_n_d = (state_d != FRAME);
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            tmr_q   <= 16'd0;
            mask_q  <= 4'd0;
            ch_q    <= 2'd0;
            cnt_q   <= 8'd0;
            div_q   <= 8'd0;
            phase_q <= 5'd0;
            shift_q <= 12'd0;
            sclk_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            sch_q   <= 2'd0;
            sdata_q <= 12'd0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            valid_q <= valid_d;
            sch_q   <= sch_d;
            sdata_q <= sdata_d;
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign ch_sel       = ch_q;
    assign sample_valid = valid_q;
    assign sample_ch    = sch_q;
    assign sample_data  = sdata_q;
    assign busy         = busy_q;
    assign overrun      = ovr_q;

endmodule
